pixel_stream_buffer: RTL and testbench

PIXEL_STREAM_BUFFER -- requirements
Module: pixel_stream_buffer

---
 rtl/pixel_stream_buffer.sv | 148 ++++++++++++++
 tb/tb_pixel_stream_buffer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_buffer.sv
// Pixel FIFO between a pixel source and the DAC stage, realigned to the display timing.
// Optional macro: PIXEL_UNDERFLOW_COUNT_EN adds the saturating underflow_count output.
//
// Ports:
//   clk25           pixel clock; all logic runs in this one domain
//   rst_n           asynchronous active-low reset
//   in_pixel        upstream pixel data
//   in_sof          marks in_pixel as the first pixel of a frame
//   in_valid        upstream data valid
//   in_ready        high while the FIFO has room; a push is in_valid && in_ready
//   in_display_area high for visible pixels (from the pixel counter)
//   frame_start     one-cycle pulse, one cycle before the first visible pixel
//   pixel_out       registered pixel to the DAC, black when nothing is shown
//   underflow       sticky per-frame flag: a visible pixel had no data
//   fill_level      current number of buffered entries
//   underflow_count (macro only) starved visible cycles, saturating, reset-only clear

module pixel_stream_buffer #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 16
) (
    input  logic                     clk25,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         in_pixel,
    input  logic                     in_sof,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_display_area,
    input  logic                     frame_start,
    output logic [WIDTH-1:0]         pixel_out,
    output logic                     underflow,
`ifdef PIXEL_UNDERFLOW_COUNT_EN
    output logic [15:0]              underflow_count,
`endif
    output logic [$clog2(DEPTH):0]   fill_level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        SYNC,
        ARMED,
        STREAM
    } state_t;

    // Each entry carries the SOF marker above the pixel bits.
    logic [WIDTH:0]  mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    state_t          state;
    state_t          state_nx;
    logic            sof_pend;
    logic            sof_pend_nx;
    logic            push;
    logic            pop;
    logic            show;
    logic            empty;
    logic            head_sof;
    logic [WIDTH:0]  head;
    logic            starve;

    assign head       = mem[rd_ptr];
    assign empty      = (count == '0);
    assign head_sof   = !empty && head[WIDTH];
    assign in_ready   = (count < FULL);
    assign push       = in_valid && in_ready;
    assign fill_level = count;
    assign starve     = in_display_area && !show;

    // pop  : an entry leaves the FIFO (discarded in SYNC, shown in STREAM)
    // show : the popped entry goes to the display
    // sof_pend lets exactly one SOF entry through after each frame_start.
    always_comb begin
        state_nx    = state;
        sof_pend_nx = sof_pend;
        pop         = 1'b0;
        show        = 1'b0;
        unique case (state)
            SYNC: begin
                if (!empty) begin
                    if (head[WIDTH]) state_nx = ARMED;
                    else             pop      = 1'b1;
                end
            end
            ARMED: begin
                if (frame_start) begin
                    state_nx    = STREAM;
                    sof_pend_nx = 1'b1;
                end
            end
            STREAM: begin
                if (in_display_area && !empty &&
                    (!head[WIDTH] || sof_pend)) begin
                    pop         = 1'b1;
                    show        = 1'b1;
                    sof_pend_nx = 1'b0;
                end
                // New frame: carry on only if the source is aligned.
                if (frame_start) begin
                    if (head_sof) sof_pend_nx = 1'b1;
                    else          state_nx    = SYNC;
                end
            end
            default: state_nx = SYNC;
        endcase
    end

    // Storage is not reset; pointers and count define what is valid.
    always_ff @(posedge clk25) begin
        if (push) mem[wr_ptr] <= {in_sof, in_pixel};
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SYNC;
            sof_pend  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pixel_out <= '0;
            underflow <= 1'b0;
        end else begin
            state    <= state_nx;
            sof_pend <= sof_pend_nx;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            pixel_out <= show ? head[WIDTH-1:0] : '0;
            // Setting beats the frame_start clear.
            if (starve)           underflow <= 1'b1;
            else if (frame_start) underflow <= 1'b0;
        end
    end

`ifdef PIXEL_UNDERFLOW_COUNT_EN
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            underflow_count <= '0;
        end else if (starve && (underflow_count != 16'hFFFF)) begin
            underflow_count <= underflow_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pixel_stream_buffer.sv
// Scoreboard bench for pixel_stream_buffer: queue-based reference model,
// random source traffic over several frames plus directed corner cases.

module tb_pixel_stream_buffer;

    localparam int DEPTH = 64;
    localparam int WIDTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int FPIX  = 160;

    logic              clk25 = 1'b0;
    logic              rst_n = 1'b1;
    logic [WIDTH-1:0]  in_pixel = '0;
    logic              in_sof = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_display_area = 1'b0;
    logic              frame_start = 1'b0;
    logic [WIDTH-1:0]  pixel_out;
    logic              underflow;
    logic [LW-1:0]     fill_level;
`ifdef PIXEL_UNDERFLOW_COUNT_EN
    logic [15:0]       underflow_count;
`endif

    always #20 clk25 = ~clk25;

    pixel_stream_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk25           (clk25),
        .rst_n           (rst_n),
        .in_pixel        (in_pixel),
        .in_sof          (in_sof),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_display_area (in_display_area),
        .frame_start     (frame_start),
        .pixel_out       (pixel_out),
        .underflow       (underflow),
`ifdef PIXEL_UNDERFLOW_COUNT_EN
        .underflow_count (underflow_count),
`endif
        .fill_level      (fill_level)
    );

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(string name, logic [31:0] act,
                                logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, req, $time);
        end
    endfunction

    typedef struct {
        logic [15:0] pix;
        logic        uf;
        int          fill;
        logic        rdy;
        int          cnt;
    } exp_t;

    exp_t expq[$];

    // Reference model: a plain queue of {sof, pixel} plus the alignment mode.
    typedef enum { M_HUNT, M_WAIT, M_PLAY } mode_t;
    logic [16:0] mq[$];
    mode_t       mode;
    bit          need_sof;
    bit          m_uf;
    int          m_cnt;

    int          src_idx;
    logic [15:0] cur_pix;

    task automatic model_reset();
        mq.delete();
        expq.delete();
        mode     = M_HUNT;
        need_sof = 0;
        m_uf     = 0;
        m_cnt    = 0;
        src_idx  = 0;
    endtask

    task automatic step(input bit v, input logic [15:0] p, input bit s,
                        input bit d, input bit fs, output bit acc);
        bit          hs;
        bit          show;
        int          nb;
        logic [15:0] outp;
        exp_t        e;
        @(negedge clk25);
        in_valid        = v;
        in_pixel        = p;
        in_sof          = s;
        in_display_area = d;
        frame_start     = fs;
        nb   = mq.size();
        hs   = (nb > 0) && mq[0][16];
        show = 0;
        outp = '0;
        case (mode)
            M_HUNT: if (nb > 0) begin
                if (hs) mode = M_WAIT;
                else    void'(mq.pop_front());
            end
            M_WAIT: if (fs) begin
                mode     = M_PLAY;
                need_sof = 1;
            end
            M_PLAY: begin
                if (d && nb > 0 && (!hs || need_sof)) begin
                    show     = 1;
                    outp     = mq[0][15:0];
                    need_sof = 0;
                    void'(mq.pop_front());
                end
                if (fs) begin
                    if (hs) need_sof = 1;
                    else    mode = M_HUNT;
                end
            end
            default: mode = M_HUNT;
        endcase
        acc = v && (nb < DEPTH);
        if (acc) mq.push_back({s, p});
        if (d && !show) begin
            m_uf = 1;
            if (m_cnt < 65535) m_cnt++;
        end else if (fs) begin
            m_uf = 0;
        end
        e.pix  = outp;
        e.uf   = m_uf;
        e.fill = mq.size();
        e.rdy  = (mq.size() < DEPTH);
        e.cnt  = m_cnt;
        expq.push_back(e);
    endtask

    // Monitor: every clock, compare DUT outputs with the oldest expectation.
    initial begin
        forever begin
            exp_t e;
            @(posedge clk25);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("pixel_out", 32'(pixel_out), 32'(e.pix));
                chk("underflow", 32'(underflow), 32'(e.uf));
                chk("fill_level", 32'(fill_level), e.fill);
                chk("in_ready", 32'(in_ready), 32'(e.rdy));
`ifdef PIXEL_UNDERFLOW_COUNT_EN
                chk("underflow_count", 32'(underflow_count), e.cnt);
`endif
            end
        end
    end

    task automatic do_reset();
        @(negedge clk25);
        #5;
        rst_n           = 1'b0;
        in_valid        = 1'b0;
        in_sof          = 1'b0;
        in_display_area = 1'b0;
        frame_start     = 1'b0;
        #1;
        chk("rst_fill", 32'(fill_level), 0);
        chk("rst_pixel", 32'(pixel_out), 0);
        chk("rst_underflow", 32'(underflow), 0);
        chk("rst_ready", 32'(in_ready), 1);
`ifdef PIXEL_UNDERFLOW_COUNT_EN
        chk("rst_count", 32'(underflow_count), 0);
`endif
        @(negedge clk25);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic src(input int prob, input bit d, input bit fs);
        bit v;
        bit acc;
        v = ($urandom_range(99) < prob);
        step(v, cur_pix, src_idx == 0, d, fs, acc);
        if (acc) begin
            src_idx = (src_idx + 1) % FPIX;
            cur_pix = 16'($urandom);
        end
    endtask

    // 4 lines of 40 visible pixels, 24 blanking cycles each, 40 of vblank.
    task automatic run_frame(input int prob);
        src(prob, 0, 1);
        for (int ln = 0; ln < 4; ln++) begin
            for (int x = 0; x < 40; x++) src(prob, 1, 0);
            for (int x = 0; x < 24; x++) src(prob, 0, 0);
        end
        for (int x = 0; x < 40; x++) src(prob, 0, 0);
    endtask

    task automatic after_edge();
        @(posedge clk25);
        #2;
    endtask

    initial begin
        bit acc;
        cur_pix = 16'($urandom);
        model_reset();
        do_reset();

        // Fill to the brim with no reads: first entry carries SOF.
        for (int i = 0; i < DEPTH; i++) src(100, 0, 0);
        after_edge();
        chk("full_ready", 32'(in_ready), 0);
        chk("full_level", 32'(fill_level), DEPTH);
        src(100, 0, 0);

        // Streaming with well-fed, starved and recovering sources.
        run_frame(100);
        run_frame(100);
        run_frame(60);
        run_frame(35);
        run_frame(100);
        run_frame(100);
        run_frame(100);
        run_frame(80);

        // Misaligned source: three stray pixels before the SOF.
        do_reset();
        step(1, 16'h1111, 0, 0, 0, acc);
        step(1, 16'h2222, 0, 0, 0, acc);
        step(1, 16'h3333, 0, 0, 0, acc);
        step(1, 16'hF800, 1, 0, 0, acc);
        for (int i = 1; i <= 4; i++)
            step(1, 16'(i), 0, 0, 0, acc);
        step(0, 16'h0, 0, 0, 0, acc);
        step(0, 16'h0, 0, 0, 1, acc);
        step(0, 16'h0, 0, 1, 0, acc);
        after_edge();
        chk("sof_first", 32'(pixel_out), 32'h0000_F800);
        for (int i = 0; i < 6; i++) step(0, 16'h0, 0, 1, 0, acc);
        after_edge();
        chk("drain_black", 32'(pixel_out), 0);
        chk("drain_uf", 32'(underflow), 1);

        // SOF reaches the head mid-line.
        step(1, 16'hAAAA, 0, 0, 0, acc);
        step(1, 16'h07E0, 1, 0, 0, acc);
        step(0, 16'h0, 0, 1, 0, acc);
        step(0, 16'h0, 0, 1, 0, acc);
        after_edge();
        chk("midsof_black", 32'(pixel_out), 0);
        chk("midsof_uf", 32'(underflow), 1);
        chk("midsof_held", 32'(fill_level), 1);
        step(0, 16'h0, 0, 0, 1, acc);
        after_edge();
        chk("fs_clear_uf", 32'(underflow), 0);
        step(0, 16'h0, 0, 1, 0, acc);
        after_edge();
        chk("resume_sof", 32'(pixel_out), 32'h0000_07E0);

        // Source behind: non-SOF head at frame_start drops back to hunting.
        step(1, 16'h1234, 0, 0, 0, acc);
        step(0, 16'h0, 0, 0, 1, acc);
        step(0, 16'h0, 0, 0, 0, acc);
        after_edge();
        chk("behind_discard", 32'(fill_level), 0);

        // Ten pixels then starvation with the display area held.
        do_reset();
        for (int i = 0; i < 10; i++)
            step(1, 16'(16'h0100 + i), i == 0, 0, 0, acc);
        step(0, 16'h0, 0, 0, 1, acc);
        for (int i = 0; i < 14; i++) step(0, 16'h0, 0, 1, 0, acc);
        step(0, 16'h0, 0, 0, 1, acc);
        after_edge();
        chk("starve_cleared", 32'(underflow), 0);

        // Reset while streaming with 20 entries buffered.
        do_reset();
        for (int i = 0; i < 31; i++)
            step(1, 16'($urandom), i == 0, 0, 0, acc);
        step(0, 16'h0, 0, 0, 1, acc);
        for (int i = 0; i < 11; i++) step(0, 16'h0, 0, 1, 0, acc);
        after_edge();
        chk("pre_reset_fill", 32'(fill_level), 20);
        do_reset();
        run_frame(100);

`ifdef PIXEL_UNDERFLOW_COUNT_EN
        do_reset();
        for (int i = 0; i < 65600; i++) step(0, 16'h0, 0, 1, 0, acc);
        after_edge();
        chk("count_sat", 32'(underflow_count), 32'h0000_FFFF);
`endif

        repeat (3) @(negedge clk25);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
